dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back line controller for the MA-stage data RAM. It holds the tag, valid and dirty state and checks every CPU load and store for a hit. On a miss it stalls the pipeline, writes the victim line back to DRAM if it is dirty, then fills the new 128-bit line into the data RAM through its full-line port. It sits between the MA-stage CPU access path and the DRAM controller, and is the sole driver of the data RAM `*_all` ports.

## Interface
- `DWIDTH`, default 11: data RAM word-address width.
  - 2^(DWIDTH-2) lines of 128 bits.
  - index = `cpu_adr[DWIDTH+1:4]`, tag = `cpu_adr[31:DWIDTH+2]`, DRAM line address = `adr[31:4]`.
- Reset is `rst_n`, asynchronous, active-low. Clock is `clk`.
- Ports:
  - `clk` in 1: clock
  - `rst_n` in 1: async active-low reset
  - `cpu_req` in 1: MA-stage load/store valid
  - `cpu_we` in 1: access is a store
  - `cpu_adr` in 32: byte address
  - `cpu_stall` out 1: hold MA and upstream stages
  - `ram_radr_all` out DWIDTH-2: line read index
  - `ram_ren_all` out 1: full-line read enable; data arrives 1 cycle later
  - `ram_rdata_all` in 128: line read data
  - `ram_wadr_all` out DWIDTH-2: line write index
  - `ram_wdata_all` out 128: line write data
  - `ram_wen_all` out 1: full-line write enable
  - `dram_req` out 1: DRAM request, held until ack
  - `dram_we` out 1: 1 = line write-back, 0 = line fetch
  - `dram_adr` out 28: DRAM line address
  - `dram_wdata` out 128: write-back data
  - `dram_ack` in 1: single-cycle completion pulse; may arrive in the first request cycle
  - `dram_rdata` in 128: fetch data, valid with `dram_ack`

## Operation
- **Hit:** `hit = valid[idx] & (tag[idx] == cpu_tag)`, computed combinationally from registers.
- **Stall:** `cpu_stall = (state != IDLE) | (cpu_req & ~hit)`.
- **Store hit in IDLE:** sets `dirty[idx]`. A store miss is retried by the CPU after the fill, and then sets dirty as a hit.
- **Miss capture:** on a miss in IDLE, `cpu_adr[31:4]` is latched into `miss_adr`.
  - The victim's {tag, idx} is latched into `wb_adr`.
  - Next state is WB_RD if `valid & dirty`, otherwise FILL_REQ.
- **States:**
  - IDLE: waits for a miss (or a flush request when configured).
  - WB_RD: `ram_ren_all=1`, `ram_radr_all=idx`, for 1 cycle; then WB_CAP.
  - WB_CAP: register `ram_rdata_all` into `dram_wdata`; then WB_REQ.
  - WB_REQ: `dram_req=1`, `dram_we=1`, `dram_adr=wb_adr`. Stays until `dram_ack`, then FILL_REQ.
  - FILL_REQ: `dram_req=1`, `dram_we=0`, `dram_adr=miss_adr`. Stays until `dram_ack`; latch `dram_rdata` into `ram_wdata_all`; then FILL_WR.
  - FILL_WR: `ram_wen_all=1`, `ram_wadr_all=idx`. Set `valid=1`, `tag=miss tag`, `dirty=0`; then IDLE.
- **DRAM outputs:** `dram_req`, `dram_we` and `dram_adr` are registered and stable while the request is pending.
- **Stray ack:** `dram_ack` outside WB_REQ/FILL_REQ is ignored.
- **Idle outputs:** all `*_all` enables are 0 outside their states; data/address outputs are don't-care when not enabled.
- **CPU during stall:** `cpu_req`/`cpu_adr` are ignored while state != IDLE. The CPU re-presents the access after the stall drops.

## Timing
- **Reset values:**
  - state IDLE; all valid and dirty cleared.
  - `dram_req`, `dram_we`, `ram_ren_all`, `ram_wen_all` = 0.
  - `dram_adr`, `dram_wdata`, `ram_wdata_all` = 0.
  - `cpu_stall` = 0 unless `cpu_req` is asserted, since every line is invalid.
- **Reset mid-operation:** returns immediately to IDLE and drops `dram_req` asynchronously. An outstanding DRAM transaction is abandoned.
- **Hit:** 0 stall cycles.
- **Clean miss, ack in first request cycle:**
  - cycle 0: detect miss.
  - cycle 1: FILL_REQ.
  - cycle 2: FILL_WR.
  - cycle 3: IDLE, hit, stall low.
  - Total: 3 stall cycles plus 1 per extra ack-wait cycle.
- **Dirty miss:** WB_RD, WB_CAP, WB_REQ, FILL_REQ, FILL_WR; 6 stall cycles minimum.
- **Fill-to-read:** the line written in FILL_WR is readable by the CPU read issued in the following cycle.

## Configuration
- Macro `DCACHE_FLUSH_EN`.
- **Defined:**
  - Adds ports `flush_req` (in 1) and `flush_done` (out 1, one-cycle pulse).
  - `flush_req` is accepted in IDLE only when `cpu_req=0`.
  - The controller walks idx 0..2^(DWIDTH-2)-1. Each dirty line goes through WB_RD/WB_CAP/WB_REQ. Each line is invalidated and its dirty bit cleared.
  - `cpu_stall=1` throughout the walk.
  - `flush_done` pulses on the cycle the controller returns to IDLE.
- **Undefined:** no flush ports, no flush states.

## Test plan
- **Cold read miss:** after reset, read 0x0000_0040.
  - Required: stall; `dram_req=1`, `dram_we=0`, `dram_adr=0x0000004`.
  - Ack with rdata 0x…CAFE: `ram_wen_all` at idx 4 with that data; stall low on cycle 3.
  - Repeat the read: 0 stall.
- **Dirty eviction:** store-hit 0x40, then read 0x2040 (idx 4, tag 1).
  - Required: `ram_ren_all` at idx 4.
  - DRAM write to `adr` 0x0000004 carrying the line read from `ram_rdata_all`.
  - Then fetch from 0x0000204; 6 stall cycles with immediate acks.
- **Clean eviction:** read 0x40, then read 0x2040 with no store.
  - Required: no write-back; a single fetch from 0x0000204.
- **Ack latency:** delay `dram_ack` by 0, 1 and 20 cycles.
  - Required: `dram_req`, `dram_adr` and `cpu_stall` stable until ack; a stray ack in IDLE changes nothing.
- **Reset in WB_REQ:** assert `rst_n=0`.
  - Required: `dram_req` goes to 0 without a clock edge; after release, a read of 0x40 misses.
- **Flush (`DCACHE_FLUSH_EN` defined):** two dirty lines, idx 3 and 7.
  - Required: exactly two DRAM writes, in idx order; `flush_done` pulses once; all lines miss afterwards.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back line controller for the MA-stage data RAM: tag/valid/dirty
// state, hit check, victim write-back and line fill. Define DCACHE_FLUSH_EN for the flush walk.
module dcache_ctrl #(
    parameter int DWIDTH = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_adr,
    output logic              cpu_stall,
    output logic [DWIDTH-3:0] ram_radr_all,
    output logic              ram_ren_all,
    input  logic [127:0]      ram_rdata_all,
    output logic [DWIDTH-3:0] ram_wadr_all,
    output logic [127:0]      ram_wdata_all,
    output logic              ram_wen_all,
    output logic              dram_req,
    output logic              dram_we,
    output logic [27:0]       dram_adr,
    output logic [127:0]      dram_wdata,
    input  logic              dram_ack,
`ifdef DCACHE_FLUSH_EN
    input  logic              flush_req,
    output logic              flush_done,
`endif
    input  logic [127:0]      dram_rdata
);

    localparam int IW    = DWIDTH - 2;
    localparam int TW    = 30 - DWIDTH;
    localparam int LINES = 1 << IW;

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_CAP,
        WB_REQ,
        FILL_REQ,
        FILL_WR
`ifdef DCACHE_FLUSH_EN
        , FL_CHK
`endif
    } state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [LINES-1:0]  dirty;
    logic [TW-1:0]     tag_mem [LINES];
    logic [27:0]       miss_adr;
    logic [27:0]       wb_adr;

    logic [IW-1:0]     cpu_idx;
    logic [TW-1:0]     cpu_tag;
    logic [IW-1:0]     miss_idx;
    logic [TW-1:0]     miss_tag;
    logic              hit;
    logic              unused_byte_bits;

`ifdef DCACHE_FLUSH_EN
    logic              flushing;
    logic [IW-1:0]     fl_idx;
`endif

    assign cpu_idx          = cpu_adr[DWIDTH+1:4];
    assign cpu_tag          = cpu_adr[31:DWIDTH+2];
    assign miss_idx         = miss_adr[IW-1:0];
    assign miss_tag         = miss_adr[27:IW];
    assign unused_byte_bits = ^cpu_adr[3:0];

    assign hit       = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign cpu_stall = (state != IDLE) || (cpu_req && !hit);

    // Tags carry no reset: an entry is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (state == FILL_WR) begin
            tag_mem[miss_idx] <= miss_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            valid         <= '0;
            dirty         <= '0;
            miss_adr      <= '0;
            wb_adr        <= '0;
            dram_req      <= 1'b0;
            dram_we       <= 1'b0;
            dram_adr      <= '0;
            dram_wdata    <= '0;
            ram_ren_all   <= 1'b0;
            ram_wen_all   <= 1'b0;
            ram_radr_all  <= '0;
            ram_wadr_all  <= '0;
            ram_wdata_all <= '0;
`ifdef DCACHE_FLUSH_EN
            flushing      <= 1'b0;
            fl_idx        <= '0;
            flush_done    <= 1'b0;
`endif
        end else begin
            ram_ren_all <= 1'b0;
            ram_wen_all <= 1'b0;
`ifdef DCACHE_FLUSH_EN
            flush_done  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (cpu_req && cpu_we && hit) begin
                        dirty[cpu_idx] <= 1'b1;
                    end
                    if (cpu_req && !hit) begin
                        miss_adr <= cpu_adr[31:4];
                        wb_adr   <= {tag_mem[cpu_idx], cpu_idx};
                        if (valid[cpu_idx] && dirty[cpu_idx]) begin
                            ram_ren_all  <= 1'b1;
                            ram_radr_all <= cpu_idx;
                            state        <= WB_RD;
                        end else begin
                            dram_req <= 1'b1;
                            dram_we  <= 1'b0;
                            dram_adr <= cpu_adr[31:4];
                            state    <= FILL_REQ;
                        end
                    end
`ifdef DCACHE_FLUSH_EN
                    if (!cpu_req && flush_req) begin
                        flushing <= 1'b1;
                        fl_idx   <= '0;
                        state    <= FL_CHK;
                    end
`endif
                end
                WB_RD: begin
                    state <= WB_CAP;
                end
                // RAM read data lands one cycle after the enable.
                WB_CAP: begin
                    dram_wdata <= ram_rdata_all;
                    dram_req   <= 1'b1;
                    dram_we    <= 1'b1;
                    dram_adr   <= wb_adr;
                    state      <= WB_REQ;
                end
                WB_REQ: begin
                    if (dram_ack) begin
`ifdef DCACHE_FLUSH_EN
                        if (flushing) begin
                            dram_req       <= 1'b0;
                            dram_we        <= 1'b0;
                            valid[fl_idx]  <= 1'b0;
                            dirty[fl_idx]  <= 1'b0;
                            if (&fl_idx) begin
                                flushing   <= 1'b0;
                                flush_done <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                fl_idx <= fl_idx + 1'b1;
                                state  <= FL_CHK;
                            end
                        end else begin
                            dram_we  <= 1'b0;
                            dram_adr <= miss_adr;
                            state    <= FILL_REQ;
                        end
`else
                        dram_we  <= 1'b0;
                        dram_adr <= miss_adr;
                        state    <= FILL_REQ;
`endif
                    end
                end
                FILL_REQ: begin
                    if (dram_ack) begin
                        dram_req      <= 1'b0;
                        ram_wdata_all <= dram_rdata;
                        ram_wen_all   <= 1'b1;
                        ram_wadr_all  <= miss_idx;
                        state         <= FILL_WR;
                    end
                end
                FILL_WR: begin
                    valid[miss_idx] <= 1'b1;
                    dirty[miss_idx] <= 1'b0;
                    state           <= IDLE;
                end
`ifdef DCACHE_FLUSH_EN
                // One line per visit: dirty lines detour through write-back, the rest drop at once.
                FL_CHK: begin
                    if (valid[fl_idx] && dirty[fl_idx]) begin
                        wb_adr       <= {tag_mem[fl_idx], fl_idx};
                        ram_ren_all  <= 1'b1;
                        ram_radr_all <= fl_idx;
                        state        <= WB_RD;
                    end else begin
                        valid[fl_idx] <= 1'b0;
                        dirty[fl_idx] <= 1'b0;
                        if (&fl_idx) begin
                            flushing   <= 1'b0;
                            flush_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            fl_idx <= fl_idx + 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed steps plus random accesses against a line-level cache/DRAM model.
module tb_dcache_ctrl;

    localparam int DW = 11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req;
    logic         cpu_we;
    logic [31:0]  cpu_adr;
    logic         cpu_stall;
    logic [8:0]   ram_radr_all;
    logic         ram_ren_all;
    logic [127:0] ram_rdata_all;
    logic [8:0]   ram_wadr_all;
    logic [127:0] ram_wdata_all;
    logic         ram_wen_all;
    logic         dram_req;
    logic         dram_we;
    logic [27:0]  dram_adr;
    logic [127:0] dram_wdata;
    logic         dram_ack;
    logic [127:0] dram_rdata;
`ifdef DCACHE_FLUSH_EN
    logic         flush_req;
    logic         flush_done;
    int           done_cnt;
`endif

    always #5 clk = ~clk;

    dcache_ctrl #(.DWIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_adr       (cpu_adr),
        .cpu_stall     (cpu_stall),
        .ram_radr_all  (ram_radr_all),
        .ram_ren_all   (ram_ren_all),
        .ram_rdata_all (ram_rdata_all),
        .ram_wadr_all  (ram_wadr_all),
        .ram_wdata_all (ram_wdata_all),
        .ram_wen_all   (ram_wen_all),
        .dram_req      (dram_req),
        .dram_we       (dram_we),
        .dram_adr      (dram_adr),
        .dram_wdata    (dram_wdata),
        .dram_ack      (dram_ack),
`ifdef DCACHE_FLUSH_EN
        .flush_req     (flush_req),
        .flush_done    (flush_done),
`endif
        .dram_rdata    (dram_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Environment: data RAM, DRAM responder and the transaction log it fills.
    logic [127:0] st_data;
    logic [127:0] ram_mem [512];
    logic [127:0] dram_mem [logic [27:0]];
    int           ack_wait_total = 0;
    int           unstable_cnt = 0;
    int           force_delay = 0;
    bit           resp_en = 1'b1;
    int           stray_req_cnt = 0;
    int           stray_served = 0;
    logic         log_we [$];
    logic [27:0]  log_adr [$];
    logic [127:0] log_data [$];
    logic         r_we;
    logic [27:0]  r_adr;
    logic [127:0] r_data;
    int           r_d;

    // Reference model: what each cache line should hold, and what DRAM should hold.
    bit           ref_valid [512];
    bit           ref_dirty [512];
    logic [18:0]  ref_tag [512];
    logic [127:0] ref_line [512];
    logic [127:0] ref_dram [logic [27:0]];
    int           n_wait;
    int           base_idx;

    function automatic logic [127:0] init_line(input logic [27:0] a);
        if (a == 28'h0000004) return 128'h0123_4567_89AB_CDEF_0011_2233_4455_CAFE;
        return {a, 4'h0, 32'hDEAD_BEEF ^ {4'h0, a}, a, 4'h5, 32'h1234_5678};
    endfunction

    function automatic logic [127:0] dram_get(input logic [27:0] a);
        return dram_mem.exists(a) ? dram_mem[a] : init_line(a);
    endfunction

    function automatic logic [127:0] ref_get(input logic [27:0] a);
        return ref_dram.exists(a) ? ref_dram[a] : init_line(a);
    endfunction

    always @(posedge clk) begin
        if (ram_wen_all) ram_mem[ram_wadr_all] <= ram_wdata_all;
        if (cpu_req && cpu_we && !cpu_stall) ram_mem[cpu_adr[12:4]] <= st_data;
        if (ram_ren_all) ram_rdata_all <= ram_mem[ram_radr_all];
    end

    initial begin
        dram_ack   = 1'b0;
        dram_rdata = '0;
        forever begin
            @(negedge clk);
            dram_ack = 1'b0;
            if (rst_n && resp_en && dram_req) begin
                r_we   = dram_we;
                r_adr  = dram_adr;
                r_data = dram_wdata;
                r_d    = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                for (int k = 0; k < r_d; k++) begin
                    @(negedge clk);
                    if (dram_req !== 1'b1 || dram_we !== r_we || dram_adr !== r_adr || cpu_stall !== 1'b1)
                        unstable_cnt++;
                end
                ack_wait_total += r_d;
                dram_ack = 1'b1;
                log_we.push_back(r_we);
                log_adr.push_back(r_adr);
                if (r_we) begin
                    log_data.push_back(r_data);
                    dram_mem[r_adr] = r_data;
                end else begin
                    dram_rdata = dram_get(r_adr);
                    log_data.push_back(dram_rdata);
                end
            end else if (!dram_req && stray_served != stray_req_cnt) begin
                dram_ack   = 1'b1;
                dram_rdata = {4{$urandom}};
                stray_served++;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // One CPU access held until the stall drops; checks stall length and DRAM traffic against the model.
    task automatic do_access(input logic [31:0] adr, input bit we);
        logic [8:0]   idx;
        logic [18:0]  tg;
        logic [27:0]  line;
        logic [127:0] d;
        bit           exp_hit;
        bit           exp_wb;
        int           base;
        int           wsnap;
        int           ustart;
        int           n;
        idx     = adr[12:4];
        tg      = adr[31:13];
        line    = adr[31:4];
        d       = {$urandom, $urandom, $urandom, $urandom};
        exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_wb  = !exp_hit && ref_valid[idx] && ref_dirty[idx];
        base    = log_we.size();
        wsnap   = ack_wait_total;
        ustart  = unstable_cnt;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we  = we;
        cpu_adr = adr;
        st_data = d;
        #1;
        check("stall_on_request", cpu_stall, !exp_hit);
        if (!exp_hit) begin
            n = 1;
            while (n < 400) begin
                @(negedge clk);
                #1;
                if (!cpu_stall) break;
                n++;
            end
            check("miss_stall_cycles", n, (exp_wb ? 6 : 3) + (ack_wait_total - wsnap));
            check("dram_txn_count", log_we.size() - base, exp_wb ? 2 : 1);
            if (exp_wb) begin
                if (log_we.size() > base) begin
                    check("wb_is_write", log_we[base], 1'b1);
                    check("wb_adr", log_adr[base], {ref_tag[idx], idx});
                    check("wb_data", log_data[base], ref_line[idx]);
                end
                ref_dram[{ref_tag[idx], idx}] = ref_line[idx];
                base++;
            end
            if (log_we.size() > base) begin
                check("fetch_is_read", log_we[base], 1'b0);
                check("fetch_adr", log_adr[base], line);
            end
            ref_line[idx]  = ref_get(line);
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            ref_dirty[idx] = 1'b0;
            check("fill_ram_line", ram_mem[idx], ref_line[idx]);
            check("req_stable_during_wait", unstable_cnt - ustart, 0);
        end
        if (we) begin
            ref_dirty[idx] = 1'b1;
            ref_line[idx]  = d;
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bit          w;
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        cpu_adr = '0;
        st_data = '0;
`ifdef DCACHE_FLUSH_EN
        flush_req = 1'b0;
`endif
        for (int i = 0; i < 512; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
            ref_tag[i]   = '0;
            ref_line[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_dram_req", dram_req, 1'b0);
        check("reset_dram_we", dram_we, 1'b0);
        check("reset_ram_ren", ram_ren_all, 1'b0);
        check("reset_ram_wen", ram_wen_all, 1'b0);
        check("reset_dram_adr", dram_adr, 28'h0);
        check("reset_dram_wdata", dram_wdata, 128'h0);
        check("reset_ram_wdata", ram_wdata_all, 128'h0);
        check("reset_stall_idle", cpu_stall, 1'b0);
        cpu_req = 1'b1;
        cpu_adr = 32'h40;
        #1;
        check("reset_stall_with_req", cpu_stall, 1'b1);
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Cold read miss, then the same read hits.
        force_delay = 0;
        do_access(32'h0000_0040, 1'b0);
        check("cold_fill_cafe", ram_mem[4], 128'h0123_4567_89AB_CDEF_0011_2233_4455_CAFE);
        do_access(32'h0000_0040, 1'b0);

        // Dirty eviction then clean eviction.
        do_access(32'h0000_0040, 1'b1);
        do_access(32'h0000_2040, 1'b0);
        do_access(32'h0000_0040, 1'b0);
        do_access(32'h0000_2040, 1'b0);

        // Ack latency 1 and 20.
        do_access(32'h0000_2040, 1'b1);
        force_delay = 1;
        do_access(32'h0000_0040, 1'b1);
        force_delay = 20;
        do_access(32'h0000_2040, 1'b0);
        force_delay = 0;

        // Stray ack in IDLE.
        @(negedge clk);
        stray_req_cnt++;
        repeat (3) @(negedge clk);
        #1;
        check("stray_ack_no_req", dram_req, 1'b0);
        check("stray_ack_no_stall", cpu_stall, 1'b0);
        do_access(32'h0000_2040, 1'b0);

        // Random accesses over a few conflicting lines.
        force_delay = -1;
        for (int i = 0; i < 60; i++) begin
            a = (32'($urandom_range(0, 3)) << 13) | (32'($urandom_range(0, 3)) << 4);
            w = 1'($urandom_range(0, 1));
            do_access(a, w);
        end
        force_delay = 0;

        // Reset while a write-back request is pending.
        do_access(32'h0000_0040, 1'b1);
        resp_en = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 32'h0000_2040;
        n_wait  = 0;
        while (!(dram_req && dram_we) && n_wait < 20) begin
            @(negedge clk);
            n_wait++;
        end
        check("reached_wb_req", dram_req & dram_we, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drops_req", dram_req, 1'b0);
        check("async_reset_drops_we", dram_we, 1'b0);
        cpu_req = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        resp_en = 1'b1;
        for (int i = 0; i < 512; i++) begin
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        do_access(32'h0000_0040, 1'b0);

`ifdef DCACHE_FLUSH_EN
        // Flush with dirty lines at idx 3 and 7 and a clean line at idx 4.
        do_access(32'h0000_0030, 1'b1);
        do_access(32'h0000_0070, 1'b1);
        base_idx = log_we.size();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        done_cnt  = 0;
        n_wait    = 0;
        while (n_wait < 3000) begin
            #1;
            if (flush_done) done_cnt++;
            if (!cpu_stall) break;
            @(negedge clk);
            n_wait++;
        end
        check("flush_finished", n_wait < 3000, 1'b1);
        repeat (4) begin
            @(negedge clk);
            #1;
            if (flush_done) done_cnt++;
        end
        check("flush_done_once", done_cnt, 1);
        for (int i = 0; i < 512; i++) begin
            if (ref_valid[i] && ref_dirty[i]) begin
                if (log_we.size() > base_idx) begin
                    check("flush_wb_is_write", log_we[base_idx], 1'b1);
                    check("flush_wb_adr", log_adr[base_idx], {ref_tag[i], 9'(i)});
                    check("flush_wb_data", log_data[base_idx], ref_line[i]);
                end
                ref_dram[{ref_tag[i], 9'(i)}] = ref_line[i];
                base_idx++;
            end
            ref_valid[i] = 1'b0;
            ref_dirty[i] = 1'b0;
        end
        check("flush_wb_count", log_we.size(), base_idx);
        do_access(32'h0000_0030, 1'b0);
        do_access(32'h0000_0070, 1'b0);
        do_access(32'h0000_0040, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
